// File: rtl/bg_pixel_fifo.sv
// Background pixel FIFO: buffers fetched tile-row slices, drops SCX fine-scroll
// pixels at line start and streams BGP-mapped shades to the LCD, one per clock.
module bg_pixel_fifo #(
    parameter int DEPTH      = 16,
    parameter int LINE_WIDTH = 160
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lcd_en,
    input  logic       line_start,
    input  logic [2:0] scx_fine,
    input  logic [7:0] bgp,
    input  logic       push_valid,
    input  logic [7:0] push_lo,
    input  logic [7:0] push_hi,
    output logic       push_ready,
    input  logic       stall,
    output logic       pix_valid,
    output logic [1:0] pix_shade,
    output logic [7:0] pix_x,
    output logic       line_done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 8);
    localparam logic [CW-1:0] PUSH_N    = CW'(8);
    localparam logic [PW-1:0] RD_LAST   = PW'(DEPTH - 1);
    localparam logic [PW-1:0] WR_LAST   = PW'(DEPTH - 8);
    localparam logic [7:0]    X_LAST    = 8'(LINE_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, DISCARD, OUTPUT} state_t;

    state_t          state, state_nxt;
    logic [1:0]      mem [DEPTH];
    logic [CW-1:0]   count, count_nxt;
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [2:0]      disc;
    logic [7:0]      pop_x;
    logic            push_fire, pop_fire, out_pop, last_pop, disc_done, flush;

    function automatic logic [1:0] bgp_map(input logic [7:0] pal, input logic [1:0] idx);
        return pal[{idx, 1'b0} +: 2];
    endfunction

    // A line_start flushes the buffer, so a push in that cycle is dropped.
    assign push_ready = lcd_en && (count <= READY_MAX);
    assign push_fire  = push_valid && push_ready && !line_start;
    assign pop_fire   = lcd_en && !line_start && (state != IDLE) && (count != '0) && !stall;
    assign out_pop    = pop_fire && (state == OUTPUT);
    assign last_pop   = out_pop && (pop_x == X_LAST);
    assign disc_done  = pop_fire && (state == DISCARD) && (disc == 3'd1);
    assign flush      = line_start || last_pop;
    assign count_nxt  = count + (push_fire ? PUSH_N : '0) - (pop_fire ? CW'(1) : '0);

    always_comb begin
        state_nxt = state;
        if (line_start)
            state_nxt = (scx_fine != 3'd0) ? DISCARD : OUTPUT;
        else if (disc_done)
            state_nxt = OUTPUT;
        else if (last_pop)
            state_nxt = IDLE;
    end

    // p0: buffer control, pop issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            disc      <= '0;
            pop_x     <= '0;
            pix_valid <= 1'b0;
            pix_shade <= '0;
            pix_x     <= '0;
            line_done <= 1'b0;
        end else if (!lcd_en) begin
            state     <= IDLE;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            disc      <= '0;
            pop_x     <= '0;
            pix_valid <= 1'b0;
            pix_shade <= '0;
            pix_x     <= '0;
            line_done <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                count <= count_nxt;
                if (pop_fire)
                    rd_ptr <= (rd_ptr == RD_LAST) ? '0 : rd_ptr + PW'(1);
                if (push_fire)
                    wr_ptr <= (wr_ptr == WR_LAST) ? '0 : wr_ptr + PW'(8);
            end
            if (line_start)
                disc <= scx_fine;
            else if (pop_fire && state == DISCARD)
                disc <= disc - 3'd1;
            if (flush)
                pop_x <= '0;
            else if (out_pop)
                pop_x <= pop_x + 8'd1;
            // p1: registered pixel output
            pix_valid <= out_pop;
            line_done <= last_pop;
            if (out_pop)
                pix_shade <= bgp_map(bgp, mem[rd_ptr]);
            if (out_pop)
                pix_x <= pop_x;
            else if (line_start || line_done)
                pix_x <= '0;
        end
    end

    // Write pointer is always slice-aligned, so the 8 entries never straddle the wrap.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            for (int i = 0; i < 8; i++)
                mem[wr_ptr + PW'(i)] <= {push_hi[3'(7 - i)], push_lo[3'(7 - i)]};
        end
    end

endmodule

// File: tb/tb_bg_pixel_fifo.sv
// Bench for bg_pixel_fifo: directed vector table, corner sequences and a
// randomized run checked against a queue-based line model.
module tb_bg_pixel_fifo;

    localparam int DEPTH = 16;
    localparam int LW    = 160;

    logic       clk = 1'b0;
    logic       reset_n, lcd_en, line_start, push_valid, stall;
    logic [2:0] scx_fine;
    logic [7:0] bgp, push_lo, push_hi;
    logic       push_ready, pix_valid, line_done;
    logic [1:0] pix_shade;
    logic [7:0] pix_x;

    bg_pixel_fifo #(.DEPTH(DEPTH), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n), .lcd_en(lcd_en), .line_start(line_start),
        .scx_fine(scx_fine), .bgp(bgp), .push_valid(push_valid), .push_lo(push_lo),
        .push_hi(push_hi), .push_ready(push_ready), .stall(stall), .pix_valid(pix_valid),
        .pix_shade(pix_shade), .pix_x(pix_x), .line_done(line_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // line model: queue of colour indices plus line progress
    int q[$];
    bit m_active;
    int m_disc, m_x;
    bit e_valid, e_done;
    int e_shade, e_x;

    typedef struct {
        logic [2:0]  scx;
        logic [7:0]  pal;
        logic [7:0]  lo;
        logic [7:0]  hi;
        int          n;
        logic [15:0] shades;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        vectors++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        q.delete();
        m_active = 0; m_disc = 0; m_x = 0;
        e_valid = 0; e_done = 0; e_shade = 0; e_x = 0;
    endfunction

    function automatic bit model_ready();
        return lcd_en && (q.size() <= DEPTH - 8);
    endfunction

    function automatic void model_edge();
        bit push, pop, prev_done;
        int idx;
        if (!lcd_en) begin
            model_clear();
            return;
        end
        push = push_valid && model_ready() && !line_start;
        pop  = m_active && (q.size() > 0) && !stall && !line_start;
        prev_done = e_done;
        e_valid = 0;
        e_done  = 0;
        if (line_start) begin
            q.delete();
            m_active = 1; m_disc = int'(scx_fine); m_x = 0; e_x = 0;
            return;
        end
        if (pop) begin
            idx = q.pop_front();
            if (m_disc > 0) m_disc--;
            else begin
                e_valid = 1;
                e_shade = (int'(bgp) >> (2 * idx)) & 3;
                e_x     = m_x;
                e_done  = (m_x == LW - 1);
                m_x++;
            end
        end
        if (!e_valid && prev_done) e_x = 0;
        if (push)
            for (int i = 0; i < 8; i++)
                q.push_back(2 * int'(push_hi[7 - i]) + int'(push_lo[7 - i]));
        if (e_done) begin
            m_active = 0;
            q.delete();
        end
    endfunction

    // Called at a falling edge with inputs already set for the coming rising edge.
    task automatic step();
        #1;
        chk("push_ready", push_ready, int'(model_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("pix_valid", pix_valid, int'(e_valid));
        chk("line_done", line_done, int'(e_done));
        chk("pix_x", pix_x, e_x);
        chk("pix_shade", pix_shade, e_shade);
        @(negedge clk);
    endtask

    task automatic quiet();
        line_start = 0; push_valid = 0; stall = 0;
    endtask

    initial begin
        int got, nvalid, ndone, pushes;
        bit hit;
        tbl[0] = '{3'd0, 8'hE4, 8'hFF, 8'h00, 8, 16'h5555};
        tbl[1] = '{3'd3, 8'hE4, 8'h0F, 8'hF0, 5, 16'h0156};
        tbl[2] = '{3'd0, 8'h1B, 8'hAA, 8'hCC, 8, 16'hE4E4};
        tbl[3] = '{3'd7, 8'hE4, 8'h01, 8'h01, 1, 16'h0003};

        reset_n = 0; lcd_en = 1; scx_fine = 0; bgp = 8'hE4;
        push_lo = 0; push_hi = 0;
        quiet();
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_valid", pix_valid, 0);
        chk("rst_ready", push_ready, 1);
        reset_n = 1;
        step();

        // vector table: one slice per line, then abort by the next line_start
        for (int r = 0; r < 4; r++) begin
            quiet();
            line_start = 1; scx_fine = tbl[r].scx; bgp = tbl[r].pal;
            step();
            line_start = 0;
            push_valid = 1; push_lo = tbl[r].lo; push_hi = tbl[r].hi;
            step();
            push_valid = 0;
            got = 0;
            for (int c = 0; c < 14; c++) begin
                step();
                if (pix_valid) begin
                    if (got < tbl[r].n) begin
                        chk("tbl_shade", pix_shade, int'(tbl[r].shades[2 * got +: 2]));
                        chk("tbl_x", pix_x, got);
                    end
                    got++;
                end
            end
            chk("tbl_count", got, tbl[r].n);
        end

        // stall fills the FIFO, then drains without loss
        quiet();
        line_start = 1; scx_fine = 0; bgp = 8'hE4;
        step();
        line_start = 0; stall = 1;
        for (int k = 0; k < 2; k++) begin
            push_valid = 1; push_lo = 8'($urandom); push_hi = 8'($urandom);
            step();
        end
        push_valid = 0;
        step();
        chk("stall_full_ready", push_ready, 0);
        stall = 0;
        nvalid = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (pix_valid) nvalid++;
        end
        chk("stall_pixels", nvalid, 16);
        chk("stall_ready_back", push_ready, 1);

        // full line: 20 slices -> 160 pixels, single line_done at x=159
        quiet();
        line_start = 1; scx_fine = 0;
        step();
        line_start = 0;
        pushes = 0; nvalid = 0; ndone = 0;
        for (int c = 0; c < 400 && ndone == 0; c++) begin
            push_valid = (pushes < 20);
            push_lo = 8'($urandom); push_hi = 8'($urandom);
            if (push_valid && model_ready()) pushes++;
            step();
            if (pix_valid) nvalid++;
            if (line_done) begin
                ndone++;
                chk("done_x", pix_x, LW - 1);
            end
        end
        push_valid = 0;
        chk("line_pixels", nvalid, LW);
        chk("line_done_cnt", ndone, 1);
        step();
        chk("post_line_x", pix_x, 0);
        chk("post_line_ready", push_ready, 1);
        push_valid = 1;
        step();
        push_valid = 0;
        step();
        chk("idle_no_pop", pix_valid, 0);

        // abort at x=50
        quiet();
        line_start = 1; scx_fine = 0;
        step();
        line_start = 0;
        hit = 0;
        for (int c = 0; c < 200 && !hit; c++) begin
            push_valid = 1; push_lo = 8'($urandom); push_hi = 8'($urandom);
            step();
            if (pix_valid && pix_x == 8'd50) hit = 1;
        end
        chk("abort_reached", int'(hit), 1);
        line_start = 1; push_valid = 1;
        step();
        chk("abort_valid", pix_valid, 0);
        chk("abort_x", pix_x, 0);
        chk("abort_done", line_done, 0);
        chk("abort_empty", push_ready, 1);
        line_start = 0;
        step();
        push_valid = 0;
        got = -1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (pix_valid && got < 0) got = int'(pix_x);
        end
        chk("restart_x", got, 0);

        // async reset mid-line
        push_valid = 1;
        step();
        #2 reset_n = 0;
        #1;
        model_clear();
        chk("rst_mid_valid", pix_valid, 0);
        chk("rst_mid_x", pix_x, 0);
        chk("rst_mid_shade", pix_shade, 0);
        chk("rst_mid_done", line_done, 0);
        @(negedge clk);
        reset_n = 1;
        quiet();
        step();
        chk("rst_ready", push_ready, 1);

        // lcd disabled: ready low, line_start ignored
        lcd_en = 0; line_start = 1; push_valid = 1;
        step();
        chk("lcd_off_ready", push_ready, 0);
        lcd_en = 1; line_start = 0;
        step();
        push_valid = 0;
        step();
        chk("lcd_off_ignored", pix_valid, 0);

        // randomized run against the model
        for (int c = 0; c < 3000; c++) begin
            lcd_en     = ($urandom_range(199) != 0);
            line_start = ($urandom_range(399) == 0) || (!m_active && $urandom_range(9) == 0);
            scx_fine   = 3'($urandom);
            if ($urandom_range(49) == 0) bgp = 8'($urandom);
            push_valid = ($urandom_range(1) == 1);
            push_lo    = 8'($urandom);
            push_hi    = 8'($urandom);
            stall      = ($urandom_range(4) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
